// File: rtl/sdrc_fifo_pkg.sv
// sdrc_fifo_pkg
//   Shared types and helpers for the single-clock SDRAM bridge FIFO.
//   - fifo_level_t   : the two "almost" flags decoded from occupancy.
//   - decode_level() : turns an occupancy count into the almost flags.
package sdrc_fifo_pkg;

    typedef struct packed {
        logic afull;   // occupancy >= depth-1
        logic aempty;  // occupancy <= 1
    } fifo_level_t;

    // Occupancy runs 0..depth. Both flags are pure threshold compares
    // so they can never glitch on input activity, only on pointer moves.
    function automatic fifo_level_t decode_level(input int unsigned occ,
                                                 input int unsigned depth);
        fifo_level_t lvl;
        lvl.afull  = (occ >= depth - 1);
        lvl.aempty = (occ <= 1);
        return lvl;
    endfunction

endpackage : sdrc_fifo_pkg

// File: rtl/sdrc_fifo_ptr.sv
// sdrc_fifo_ptr
//   Wrapping pointer register with an increment enable. The MSB acts as
//   the wrap bit; the pointer rolls over naturally modulo 2^PTR_W.
//   Ports:
//     clk      in   rising-edge clock
//     reset_n  in   asynchronous active-low reset (pointer -> 0)
//     inc      in   advance the pointer by one at the next edge
//     ptr      out  current pointer value (address bits + wrap bit)
module sdrc_fifo_ptr #(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule : sdrc_fifo_ptr

// File: rtl/sdrc_fifo.sv
// sdrc_fifo
//   Single-clock first-word-fall-through FIFO used by the SDRAM controller
//   bridge for command words, masked write data and read data. Port list
//   and flag behaviour match the bridge's dual-clock FIFO.
//
//   Handshake: a push is accepted at a rising edge when wr_en=1 and full=0;
//   a pop is accepted when rd_en=1 and empty=0. A push while full is
//   silently dropped; a pop while empty is ignored. rd_data always shows
//   the head entry and is valid whenever empty=0.
//
//   Ports:
//     clk      in   single rising-edge clock
//     reset_n  in   asynchronous active-low reset
//     wr_en    in   push request
//     wr_data  in   [W]  word to push
//     full     out  all DP entries occupied
//     afull    out  occupancy >= DP-1
//     rd_en    in   pop request (head consumed at the edge)
//     rd_data  out  [W]  head entry
//     empty    out  occupancy == 0
//     aempty   out  occupancy <= 1
module sdrc_fifo
    import sdrc_fifo_pkg::*;
#(
    parameter int W  = 8,
    parameter int DP = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic         afull,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         aempty
);

    localparam int ADDR_W = $clog2(DP);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [PTR_W-1:0]  occupancy;
    logic              wr_accept;
    logic              rd_accept;
    fifo_level_t       level;

    logic [W-1:0] mem [DP];

    // Flags gate acceptance, so full wins over a simultaneous read when
    // the FIFO is full, and empty wins over a simultaneous write when it
    // is empty: the other side of the pair still goes through.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    sdrc_fifo_ptr #(.PTR_W(PTR_W)) u_wptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wr_accept),
        .ptr     (wptr)
    );

    sdrc_fifo_ptr #(.PTR_W(PTR_W)) u_rptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (rd_accept),
        .ptr     (rptr)
    );

    assign waddr = wptr[ADDR_W-1:0];
    assign raddr = rptr[ADDR_W-1:0];

    // Storage is cleared on reset so rd_data reads 0 until the first push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DP; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_accept) begin
            mem[waddr] <= wr_data;
        end
    end

    // Flags come from the pointer registers only; no input reaches an
    // output combinationally.
    assign occupancy = wptr - rptr;
    assign empty     = (wptr == rptr);
    // Same slot, different lap: the writer is exactly DP ahead.
    assign full      = (waddr == raddr) && (wptr[ADDR_W] != rptr[ADDR_W]);
    assign level     = decode_level(32'(occupancy), DP);
    assign afull     = level.afull;
    assign aempty    = level.aempty;

    // First-word fall-through: the head slot drives the output directly.
    assign rd_data   = mem[raddr];

endmodule : sdrc_fifo

// File: tb/tb_sdrc_fifo.sv
module tb_sdrc_fifo;

  localparam int W  = 8;
  localparam int DP = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         rd_en = 1'b0;
  logic         full, afull, empty, aempty;
  logic [W-1:0] rd_data;

  always #5 clk = ~clk;

  sdrc_fifo #(.W(W), .DP(DP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .afull   (afull),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .aempty  (aempty)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a bounded queue. Acceptance is decided from the
  // queue size before the edge, exactly as the flags would gate it.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      logic do_wr, do_rd;
      do_wr = wr_en && (exp_q.size() < DP);
      do_rd = rd_en && (exp_q.size() > 0);
      if (do_rd) void'(exp_q.pop_front());
      if (do_wr) exp_q.push_back(wr_data);
    end
  end

  // Compare process: every falling edge out of reset.
  always @(negedge clk) begin
    if (reset_n) begin
      int n;
      n = exp_q.size();
      chk("empty",  32'(empty),  32'(n == 0));
      chk("full",   32'(full),   32'(n == DP));
      chk("afull",  32'(afull),  32'(n >= DP - 1));
      chk("aempty", 32'(aempty), 32'(n <= 1));
      if (n > 0) chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_empty"},   32'(empty),   32'd1);
    chk({tag, "_aempty"},  32'(aempty),  32'd1);
    chk({tag, "_full"},    32'(full),    32'd0);
    chk({tag, "_afull"},   32'(afull),   32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    #1;

    // Fill
    step(1'b1, 8'h11, 1'b0);
    chk("fill1_rd_data", 32'(rd_data), 32'h11);
    chk("fill1_aempty",  32'(aempty),  32'd1);
    step(1'b1, 8'h22, 1'b0);
    chk("fill2_aempty",  32'(aempty),  32'd0);
    chk("fill2_afull",   32'(afull),   32'd0);
    step(1'b1, 8'h33, 1'b0);
    chk("fill3_afull",   32'(afull),   32'd1);
    chk("fill3_full",    32'(full),    32'd0);
    step(1'b1, 8'h44, 1'b0);
    chk("fill4_full",    32'(full),    32'd1);
    step(1'b1, 8'h55, 1'b0);
    chk("fill5_full",    32'(full),    32'd1);
    chk("fill5_head",    32'(rd_data), 32'h11);

    // Drain
    begin
      logic [W-1:0] drain_exp [4];
      drain_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("drain%0d", i), 32'(rd_data), 32'(drain_exp[i]));
        step(1'b0, 8'h00, 1'b1);
      end
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 8'h00, 1'b1);  // pop while empty
    chk("xpop_empty",  32'(empty), 32'd1);
    chk("xpop_full",   32'(full),  32'd0);

    // Simultaneous with two entries, across pointer wrap
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'hB0 + 8'(i), 1'b1);
    chk("simul_head",   32'(rd_data), 32'hB8);
    chk("simul_aempty", 32'(aempty),  32'd0);
    chk("simul_afull",  32'(afull),   32'd0);

    // Full plus simultaneous read and write: write lost
    step(1'b1, 8'hC0, 1'b0);
    step(1'b1, 8'hC1, 1'b0);
    chk("edge_full", 32'(full), 32'd1);
    step(1'b1, 8'hEE, 1'b1);
    chk("edge_full_after", 32'(full),    32'd0);
    chk("edge_afull_after", 32'(afull),  32'd1);
    chk("edge_head_after", 32'(rd_data), 32'hB9);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("edge_last", 32'(rd_data), 32'hC1);
    step(1'b0, 8'h00, 1'b1);
    chk("edge_drained", 32'(empty), 32'd1);

    // Empty plus simultaneous read and write: write kept
    step(1'b1, 8'h77, 1'b1);
    chk("emp_rw_empty",   32'(empty),   32'd0);
    chk("emp_rw_aempty",  32'(aempty),  32'd1);
    chk("emp_rw_rd_data", 32'(rd_data), 32'h77);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-fill, away from any edge
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h6B, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h3C, 1'b0);
    chk("post_arst_rd_data", 32'(rd_data), 32'h3C);
    for (int i = 0; i < 50; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sdrc_fifo
